// File: rtl/shdw_dump_sched_if.sv
// rtl/shdw_dump_sched_if.sv - bus bundle between the register slave / shadow chains and the dump scheduler
//
// Purpose: groups the control, chain and FIFO read signals of shdw_dump_sched.
// Ports (modport slave = scheduler view):
//   in : start, abort, req_mask, sh_out, sh_out_vld, sh_out_done, rd_en
//   out: c_en, dump_en, rd_data, rd_chain, rd_empty, busy, done, overflow, timeout_err
interface shdw_dump_sched_if #(
  parameter int NUM_CHAINS = 32,
  parameter int DATA_W     = 32
);
  localparam int IW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

  logic                  start;
  logic                  abort;
  logic [NUM_CHAINS-1:0] req_mask;
  logic                  c_en;
  logic [NUM_CHAINS-1:0] dump_en;
  logic [DATA_W-1:0]     sh_out;
  logic [NUM_CHAINS-1:0] sh_out_vld;
  logic [NUM_CHAINS-1:0] sh_out_done;
  logic                  rd_en;
  logic [DATA_W-1:0]     rd_data;
  logic [IW-1:0]         rd_chain;
  logic                  rd_empty;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic                  timeout_err;

  modport slave (
    input  start, abort, req_mask, sh_out, sh_out_vld, sh_out_done, rd_en,
    output c_en, dump_en, rd_data, rd_chain, rd_empty, busy, done, overflow, timeout_err
  );

  modport master (
    output start, abort, req_mask, sh_out, sh_out_vld, sh_out_done, rd_en,
    input  c_en, dump_en, rd_data, rd_chain, rd_empty, busy, done, overflow, timeout_err
  );
endinterface

// File: rtl/shdw_dump_sched.sv
// rtl/shdw_dump_sched.sv - shadow-scan dump sequencer with round-robin grant and capture FIFO
//
// Purpose: freezes the core, grants dump_en one-hot to each requested chain in round-robin
// order, captures {chain, word} into a first-word fall-through FIFO, then re-enables the core.
// Ports:
//   Bus2IP_Clk   in  clock
//   Bus2IP_Reset in  asynchronous active-high reset
//   bus          shdw_dump_sched_if.slave (control, chain handshake, FIFO read, status)
module shdw_dump_sched #(
  parameter int NUM_CHAINS = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int QUIESCE    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             Bus2IP_Clk,
  input  logic             Bus2IP_Reset,
  shdw_dump_sched_if.slave bus
);
  localparam int IW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int QW = $clog2(QUIESCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FREEZE, SELECT, DUMP, FINISH} state_t;

  state_t                state_q, state_d;
  logic [NUM_CHAINS-1:0] pending_q;
  logic [IW-1:0]         gnt_q;
  logic [IW-1:0]         rr_q;
  logic [IW-1:0]         sel_idx;
  logic                  sel_found;
  logic [QW-1:0]         q_cnt;
  logic [TW-1:0]         timer_q;
  logic                  overflow_q;
  logic                  tmo_err_q;

  logic [IW+DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [IW+DATA_W-1:0]  head;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  full, empty, pop_ok;

  logic                  vld_g, done_g, timer_hit;
  logic                  start_ok, grant_go, chain_end, push_ok, drop, tmo;
  logic [NUM_CHAINS-1:0] dump_en_w;

  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign pop_ok = bus.rd_en && !empty;
  assign vld_g  = bus.sh_out_vld[gnt_q];
  assign done_g = bus.sh_out_done[gnt_q];
  // The timer is frozen while the FIFO stalls the chain, so backpressure never
  // looks like a dead chain.
  assign timer_hit = (timer_q == TW'(TIMEOUT - 1)) && !vld_g && !done_g && !full;

  // Round-robin pick: first pending index at or after rr_q, wrapping past the top.
  always_comb begin : p_sel
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      j = (int'(rr_q) + i) % NUM_CHAINS;
      if (!sel_found && pending_q[j]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    grant_go  = 1'b0;
    chain_end = 1'b0;
    push_ok   = 1'b0;
    drop      = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = FREEZE;
        end
      end
      FREEZE: begin
        if (bus.abort)                       state_d = FINISH;
        else if (q_cnt == QW'(QUIESCE - 1))  state_d = SELECT;
      end
      SELECT: begin
        if (bus.abort || !sel_found) begin
          state_d = FINISH;
        end else begin
          grant_go = 1'b1;
          state_d  = DUMP;
        end
      end
      DUMP: begin
        // A pop in the same cycle frees the slot, so a push at full still lands.
        push_ok = vld_g && (!full || pop_ok);
        drop    = vld_g && full && !pop_ok;
        if (bus.abort) begin
          state_d = FINISH;
        end else if (done_g || timer_hit) begin
          chain_end = 1'b1;
          tmo       = timer_hit;
          state_d   = SELECT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      gnt_q      <= '0;
      rr_q       <= '0;
      q_cnt      <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        pending_q  <= bus.req_mask;
        overflow_q <= 1'b0;
        tmo_err_q  <= 1'b0;
        q_cnt      <= '0;
      end else if (state_q == FREEZE) begin
        q_cnt <= q_cnt + 1'b1;
      end

      if (grant_go) begin
        gnt_q   <= sel_idx;
        timer_q <= '0;
      end else if (state_q == DUMP) begin
        if (vld_g)      timer_q <= '0;
        else if (!full) timer_q <= timer_q + 1'b1;
      end

      if (chain_end) begin
        pending_q[gnt_q] <= 1'b0;
        rr_q <= (int'(gnt_q) == NUM_CHAINS - 1) ? '0 : gnt_q + 1'b1;
      end

      // Whatever an abort left pending is dropped here.
      if (state_q == FINISH) pending_q <= '0;

      if (drop) overflow_q <= 1'b1;
      if (tmo)  tmo_err_q  <= 1'b1;
    end
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (push_ok) mem[wr_ptr] <= {gnt_q, bus.sh_out};
  end

  assign head = mem[rd_ptr];

  always_comb begin
    dump_en_w = '0;
    if (state_q == DUMP && !full) dump_en_w[gnt_q] = 1'b1;
  end

  assign bus.c_en        = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FINISH);
  assign bus.dump_en     = dump_en_w;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.rd_empty    = empty;
  assign bus.rd_data     = empty ? '0 : head[DATA_W-1:0];
  assign bus.rd_chain    = empty ? '0 : head[IW+DATA_W-1:DATA_W];
endmodule
